sram_bus_bridge: RTL and testbench
==================================

Name: sram_bus_bridge

Overview:
- Sits directly downstream of the CPU core's instruction and data SRAM ports.
- Converts the two sram-like master ports (request / addr_ok / data_ok) into one shared single-outstanding external bus.
- Arbitrates inst vs data with fixed data priority, latches the accepted request, drives the bus handshake and returns a one-cycle data_ok with registered read data.
- The core's stall logic consumes data_ok/addr_ok.

Parameters:
- ADDR_W, 32, address width of both masters and the bus.
- DATA_W, 32, data width; must be 32 (wstrb is 4 bits).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset (0 = reset)
- inst_req  input  1  instruction read request
- inst_addr  input  ADDR_W  instruction address
- inst_addr_ok  output  1  inst request accepted this cycle
- inst_data_ok  output  1  inst read data valid (1-cycle pulse)
- inst_rdata  output  DATA_W  instruction read data
- data_req  input  1  data request
- data_wr  input  1  1 = write, 0 = read
- data_wstrb  input  4  byte enables for writes
- data_addr  input  ADDR_W  data address
- data_wdata  input  DATA_W  write data
- data_addr_ok  output  1  data request accepted this cycle
- data_data_ok  output  1  data transaction complete (1-cycle pulse)
- data_rdata  output  DATA_W  data read data
- bus_req  output  1  bus request valid
- bus_wr  output  1  bus write flag
- bus_wstrb  output  4  bus byte enables (0000 for reads)
- bus_addr  output  ADDR_W  bus address
- bus_wdata  output  DATA_W  bus write data
- bus_gnt  input  1  slave accepted the request
- bus_rvalid  input  1  slave response valid (read data or write ack)
- bus_rdata  input  DATA_W  slave read data

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs 0, including latched addr/wdata/wstrb, owner flag and rdata registers. Any in-flight transaction is abandoned and no data_ok is issued for it.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - data_addr_ok = data_req (combinational).
  - inst_addr_ok = inst_req & ~data_req. Data wins a simultaneous request; inst retries next free IDLE.
  - On acceptance (req & addr_ok), latch owner, wr, wstrb (forced 0000 on inst or reads), addr and wdata, then go to REQ.
- REQ:
  - bus_req=1 with the latched fields held stable until bus_gnt=1.
  - On bus_gnt, go to WAIT. bus_req drops the next cycle.
- WAIT:
  - bus_req=0. On bus_rvalid, capture bus_rdata into the owner's rdata register and go to RESP.
  - bus_rvalid is sampled only in WAIT and ignored in IDLE/REQ/RESP. The slave must respond no earlier than the cycle after gnt.
- RESP:
  - Owner's data_ok=1 for exactly one cycle; the other master's data_ok stays 0.
  - Go to IDLE. addr_ok stays 0 in RESP.
- addr_ok is 0 in REQ, WAIT and RESP, so at most one transaction is outstanding.
- Read data registers hold their value until the next response for the same master. data_rdata is don't-care after writes but must equal the captured bus_rdata.
- Minimum latency: accept at T0, bus_req at T1 (gnt at T1), rvalid at T2, data_ok at T3, IDLE at T4 (next accept at T4).
- No bus timeout. The bridge waits indefinitely in REQ/WAIT.
- Masters may change or drop req while not accepted; nothing is latched without addr_ok.

Test Plan:
- Inst read, 0-wait slave: inst_req, addr=0xBFC00000 at T0 → inst_addr_ok=1 at T0; bus_req=1, addr=0xBFC00000, wstrb=0000 at T1; gnt at T1, rvalid with rdata=0x3C080001 at T2 → inst_data_ok=1, inst_rdata=0x3C080001 at T3 only.
- Data write with stalled grant: data_req, wr=1, wstrb=1111, addr=0x80001000, wdata=0xDEADBEEF; gnt delayed 3 cycles → bus fields stable for all 4 REQ cycles; after rvalid, data_data_ok pulses once and inst_data_ok stays 0.
- Simultaneous requests: inst and data both request at T0 → only data_addr_ok=1. After data_data_ok, inst_addr_ok=1 in the following IDLE cycle and the inst read completes.
- No overlap: hold inst_req=1 continuously → inst_addr_ok=0 in every REQ/WAIT/RESP cycle; exactly one data_ok per accepted request over 10 back-to-back reads.
- Spurious response: bus_rvalid=1 in IDLE and in REQ → no data_ok and no state change.
- Reset mid-operation: rst=0 during WAIT → all outputs 0 immediately. The late rvalid after reset release produces no data_ok, and a new request is accepted normally.

Source files
------------

// File: rtl/sram_bus_bridge.sv
// Bridges the core's inst and data sram-like ports onto one external bus with a
// single outstanding transaction and fixed data-over-inst priority.
module sram_bus_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;  // 1 = data master owns the transaction
  logic              wr_q, wr_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0] data_rdata_q, data_rdata_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      wstrb_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    wstrb_d      = wstrb_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_addr_ok = 1'b0;
    data_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    bus_req      = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_addr_ok = data_req;
        inst_addr_ok = inst_req & ~data_req;
        if (data_req) begin
          owner_d = 1'b1;
          wr_d    = data_wr;
          wstrb_d = data_wr ? data_wstrb : '0;
          addr_d  = data_addr;
          wdata_d = data_wdata;
          state_d = REQ;
        end else if (inst_req) begin
          owner_d = 1'b0;
          wr_d    = 1'b0;
          wstrb_d = '0;
          addr_d  = inst_addr;
          wdata_d = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (bus_rvalid) begin
          if (owner_q) data_rdata_d = bus_rdata;
          else         inst_rdata_d = bus_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        inst_data_ok = ~owner_q;
        data_data_ok = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus_wr     = wr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_addr   = addr_q;
  assign bus_wdata  = wdata_q;
  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;

endmodule

// File: tb/tb_sram_bus_bridge.sv
// Bench for sram_bus_bridge: scoreboard of accepted requests checked against the
// bus fields and data_ok responses, plus directed arbitration/reset sequences.
module tb_sram_bus_bridge;

  localparam logic [31:0] K = 32'h83C8_0001;  // slave data = addr ^ K

  logic        clk, rst;
  logic        inst_req, inst_addr_ok, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_gnt, bus_rvalid;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  logic        slave_auto;
  logic        s_gnt, s_rvalid, m_gnt, m_rvalid;
  logic [31:0] s_rdata, m_rdata, s_lat_addr;
  logic        s_phase;
  int unsigned s_cnt, gnt_delay;

  assign bus_gnt    = slave_auto ? s_gnt    : m_gnt;
  assign bus_rvalid = slave_auto ? s_rvalid : m_rvalid;
  assign bus_rdata  = slave_auto ? s_rdata  : m_rdata;

  sram_bus_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0, errors = 0, inst_ok_cnt = 0, data_ok_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        owner;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  // Auto slave: grants after gnt_delay REQ cycles, responds the cycle after gnt.
  always @(negedge clk) begin
    s_gnt = 1'b0;
    s_rvalid = 1'b0;
    if (!rst || !slave_auto) begin
      s_cnt = 0;
      s_phase = 1'b0;
    end else if (!s_phase) begin
      if (bus_req) begin
        if (s_cnt >= gnt_delay) begin
          s_gnt = 1'b1;
          s_phase = 1'b1;
          s_cnt = 0;
          s_lat_addr = bus_addr;
        end else s_cnt++;
      end
    end else begin
      s_rvalid = 1'b1;
      s_rdata = s_lat_addr ^ K;
      s_phase = 1'b0;
    end
  end

  // Monitor: just before each rising edge, push accepted requests, check bus fields, pop responses.
  always @(negedge clk) begin
    #3;
    if (rst) begin
      if (inst_addr_ok || data_addr_ok) chk("no_overlap_q_size", q.size(), 0);
      if (data_addr_ok && data_req)
        q.push_back('{1'b1, data_wr, data_wr ? data_wstrb : 4'b0000, data_addr, data_wdata, data_addr ^ K});
      else if (inst_addr_ok && inst_req)
        q.push_back('{1'b0, 1'b0, 4'b0000, inst_addr, 32'h0, inst_addr ^ K});
      if (bus_req) begin
        if (q.size() == 0) chk("bus_req_unexpected", {31'b0, bus_req}, 0);
        else begin
          mon_e = q[0];
          chk("bus_addr", bus_addr, mon_e.addr);
          chk("bus_wr", {31'b0, bus_wr}, {31'b0, mon_e.wr});
          chk("bus_wstrb", {28'b0, bus_wstrb}, {28'b0, mon_e.strb});
          if (mon_e.wr) chk("bus_wdata", bus_wdata, mon_e.wdata);
        end
      end
      if (inst_data_ok) inst_ok_cnt++;
      if (data_data_ok) data_ok_cnt++;
      if (inst_data_ok || data_data_ok) begin
        if (q.size() == 0) chk("spurious_data_ok", {30'b0, inst_data_ok, data_data_ok}, 0);
        else begin
          mon_e = q.pop_front();
          chk("inst_data_ok", {31'b0, inst_data_ok}, {31'b0, ~mon_e.owner});
          chk("data_data_ok", {31'b0, data_data_ok}, {31'b0, mon_e.owner});
          if (mon_e.owner) chk("data_rdata", data_rdata, mon_e.rdata);
          else             chk("inst_rdata", inst_rdata, mon_e.rdata);
        end
      end
    end
  end

  task automatic do_req(input logic is_data, input logic wr, input logic [3:0] strb,
                        input logic [31:0] a, input logic [31:0] wd);
    int unsigned n;
    logic ok;
    @(negedge clk);
    if (is_data) begin
      data_req = 1'b1; data_wr = wr; data_wstrb = strb; data_addr = a; data_wdata = wd;
    end else begin
      inst_req = 1'b1; inst_addr = a;
    end
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      #1;
      ok = is_data ? data_addr_ok : inst_addr_ok;
      if (!ok) begin
        @(negedge clk);
        n++;
      end
    end
    if (!ok) chk("accept_timeout", {31'b0, ok}, 1);
    @(negedge clk);
    if (is_data) data_req = 1'b0;
    else         inst_req = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout_q_size", q.size(), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, {31'b0, bus_req}, 0);
    chk({tag, "_bus_wr"}, {31'b0, bus_wr}, 0);
    chk({tag, "_bus_wstrb"}, {28'b0, bus_wstrb}, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_addr_ok"}, {30'b0, inst_addr_ok, data_addr_ok}, 0);
    chk({tag, "_data_ok"}, {30'b0, inst_data_ok, data_data_ok}, 0);
    chk({tag, "_inst_rdata"}, inst_rdata, 0);
    chk({tag, "_data_rdata"}, data_rdata, 0);
  endtask

  typedef struct {
    logic ireq;
    logic dreq;
    logic exp_iok;
    logic exp_dok;
  } arb_vec_t;

  typedef struct {
    logic        is_data;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
    int unsigned gdly;
    logic [3:0]  exp_wstrb;
  } txn_t;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    arb_vec_t arb[4];
    txn_t     tx[5];
    int unsigned n, acc, base;
    logic just;

    arb[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    arb[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
    arb[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    arb[3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tx[0] = '{1'b1, 1'b0, 4'hF,    32'h8000_0010, 32'h1234_5678, 0, 4'h0};
    tx[1] = '{1'b1, 1'b1, 4'b0011, 32'h8000_0020, 32'hCAFE_F00D, 1, 4'b0011};
    tx[2] = '{1'b0, 1'b0, 4'h0,    32'h0000_0040, 32'h0,         2, 4'h0};
    tx[3] = '{1'b1, 1'b1, 4'b1000, 32'hFFFF_FFFC, 32'hA5A5_5A5A, 0, 4'b1000};
    tx[4] = '{1'b0, 1'b0, 4'h0,    32'hFFFF_FFF0, 32'h0,         5, 4'h0};

    rst = 1'b0; slave_auto = 1'b1; gnt_delay = 0;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wr = 0; data_wstrb = 0;
    data_addr = 0; data_wdata = 0; m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // Inst read, zero-wait slave: exact cycle-by-cycle timing
    do_req(1'b0, 1'b0, 4'h0, 32'hBFC0_0000, 32'h0);
    #1;
    chk("t1_bus_req", {31'b0, bus_req}, 1);
    chk("t1_bus_addr", bus_addr, 32'hBFC0_0000);
    chk("t1_bus_wstrb", {28'b0, bus_wstrb}, 0);
    @(negedge clk); #1;
    chk("t2_bus_req_dropped", {31'b0, bus_req}, 0);
    @(negedge clk); #1;
    chk("t3_inst_data_ok", {31'b0, inst_data_ok}, 1);
    chk("t3_inst_rdata", inst_rdata, 32'h3C08_0001);
    @(negedge clk); #1;
    chk("t4_inst_data_ok_low", {31'b0, inst_data_ok}, 0);
    wait_idle();

    // Data write with grant stalled 3 cycles
    gnt_delay = 3;
    do_req(1'b1, 1'b1, 4'hF, 32'h8000_1000, 32'hDEAD_BEEF);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (bus_req) n++;
      @(negedge clk);
    end
    chk("stall_req_cycles", n, 4);
    wait_idle();
    gnt_delay = 0;

    // Arbitration vectors applied between edges in IDLE
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      inst_req = arb[i].ireq; data_req = arb[i].dreq;
      inst_addr = 32'h1000; data_addr = 32'h2000; data_wr = 1'b0;
      #1;
      chk("arb_inst_addr_ok", {31'b0, inst_addr_ok}, {31'b0, arb[i].exp_iok});
      chk("arb_data_addr_ok", {31'b0, data_addr_ok}, {31'b0, arb[i].exp_dok});
      #1;
      inst_req = 1'b0; data_req = 1'b0;
    end

    // Transaction table
    for (int i = 0; i < 5; i++) begin
      gnt_delay = tx[i].gdly;
      do_req(tx[i].is_data, tx[i].wr, tx[i].strb, tx[i].addr, tx[i].wdata);
      #1 chk("tbl_bus_wstrb", {28'b0, bus_wstrb}, {28'b0, tx[i].exp_wstrb});
      wait_idle();
    end
    chk("data_rdata_hold", data_rdata, 32'hFFFF_FFFC ^ K);
    gnt_delay = 0;

    // Simultaneous requests: data first, inst retried in the IDLE after data_ok
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_2000;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'hF; data_addr = 32'h8000_4000;
    #1;
    chk("sim_data_addr_ok", {31'b0, data_addr_ok}, 1);
    chk("sim_inst_addr_ok", {31'b0, inst_addr_ok}, 0);
    @(negedge clk);
    data_req = 1'b0;
    n = 1;
    while (n < 50) begin
      #1;
      if (inst_addr_ok) break;
      @(negedge clk);
      n++;
    end
    chk("sim_inst_retry_cycle", n, 4);
    @(negedge clk);
    inst_req = 1'b0;
    wait_idle();

    // Ten back-to-back inst reads with inst_req held high
    base = inst_ok_cnt; acc = 0; just = 1'b0;
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'hBFC0_1000;
    for (int i = 0; i < 200 && acc < 10; i++) begin
      #1;
      if (inst_addr_ok) begin
        acc++;
        just = 1'b1;
      end
      @(negedge clk);
      if (just) begin
        inst_addr = inst_addr + 32'd4;
        just = 1'b0;
      end
    end
    inst_req = 1'b0;
    wait_idle();
    chk("b2b_accepts", acc, 10);
    chk("b2b_inst_data_ok", inst_ok_cnt - base, 10);

    // Spurious rvalid in IDLE, then in REQ
    slave_auto = 1'b0;
    @(negedge clk);
    m_rvalid = 1'b1; m_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    m_rvalid = 1'b0;
    #1 chk("spur_idle_bus_req", {31'b0, bus_req}, 0);
    do_req(1'b1, 1'b0, 4'hF, 32'h8000_3000, 32'h0);
    m_rvalid = 1'b1;
    #1 chk("spur_req_hold1", {31'b0, bus_req}, 1);
    @(negedge clk); #1;
    chk("spur_req_hold2", {31'b0, bus_req}, 1);
    @(negedge clk);
    m_rvalid = 1'b0; m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h8000_3000 ^ K;
    @(negedge clk);
    m_rvalid = 1'b0;
    wait_idle();

    // Reset during WAIT; late rvalid must be ignored
    do_req(1'b1, 1'b0, 4'h0, 32'h8000_2000, 32'h0);
    m_gnt = 1'b1;
    @(negedge clk);
    m_gnt = 1'b0;
    #1;
    rst = 1'b0;
    q.delete();
    #1 chk_all_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h1111_2222;
    @(negedge clk);
    m_rvalid = 1'b0;
    #1 chk("post_reset_bus_req", {31'b0, bus_req}, 0);
    slave_auto = 1'b1;
    base = data_ok_cnt;
    do_req(1'b0, 1'b0, 4'h0, 32'hBFC0_0010, 32'h0);
    wait_idle();
    chk("post_reset_no_data_ok", data_ok_cnt - base, 0);
    repeat (3) @(negedge clk);
    chk("final_q_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
